// File: rtl/alu_pkg.sv
// Shared ALU opcode constants and arbiter FSM state encoding.
package alu_pkg;

    localparam logic [3:0] OP_SLL  = 4'b0000;
    localparam logic [3:0] OP_SRL  = 4'b0001;
    localparam logic [3:0] OP_SRA  = 4'b0010;
    localparam logic [3:0] OP_AND  = 4'b1000;
    localparam logic [3:0] OP_XOR  = 4'b1001;
    localparam logic [3:0] OP_ADD  = 4'b1010;
    localparam logic [3:0] OP_DIFF = 4'b1011;
    localparam logic [3:0] OP_PASS = 4'b1110;
    localparam logic [3:0] OP_COMP = 4'b1111;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } arb_state_e;

endpackage

// File: rtl/alu_share_arbiter_rr_arb2.sv
// Two-request round-robin grant; LastGnt resets to 1 so port 0 wins the first tie.
module rr_arb2 (
    input  logic clk,
    input  logic rst_n,
    input  logic en,
    input  logic req0,
    input  logic req1,
    output logic gnt_valid,
    output logic gnt_port
);

    logic last_gnt_q, last_gnt_d;

    always_comb begin
        gnt_valid  = en && (req0 || req1);
        gnt_port   = (req0 && req1) ? ~last_gnt_q : req1;
        last_gnt_d = gnt_valid ? gnt_port : last_gnt_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_gnt_q <= 1'b1;
        end else begin
            last_gnt_q <= last_gnt_d;
        end
    end

endmodule

// File: rtl/alu_share_arbiter.sv
// Shares one ALU between the execute stage (port 0) and the address/branch unit (port 1).
// Define ALU_ARB_FLAGS_EN to capture the ALU status flags alongside Result.
module alu_share_arbiter
    import alu_pkg::*;
#(
    parameter int WIDTH   = 32,
    parameter int ALU_LAT = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             Req0,
    input  logic             Req1,
    input  logic [3:0]       Op0,
    input  logic [3:0]       Op1,
    input  logic [WIDTH-1:0] A0,
    input  logic [WIDTH-1:0] A1,
    input  logic [WIDTH-1:0] B0,
    input  logic [WIDTH-1:0] B1,
    input  logic [4:0]       Shamt0,
    input  logic [4:0]       Shamt1,
    output logic             Ack0,
    output logic             Ack1,
    output logic [WIDTH-1:0] Result,
    output logic             CarryOut,
    output logic             FlagZero,
    output logic             FlagSign,
    output logic             FlagEqual,
    output logic             Busy,
    output logic [WIDTH-1:0] AluA,
    output logic [WIDTH-1:0] AluB,
    output logic [4:0]       AluShamt,
    output logic [3:0]       AluOps,
    input  logic [WIDTH-1:0] AluOut,
    input  logic             AluCarry,
    input  logic             AluZero,
    input  logic             AluSign,
    input  logic             AluEqual
);

    localparam logic [1:0] CNT_INIT = 2'(ALU_LAT - 1);

    arb_state_e       state_q, state_d;
    logic [1:0]       cnt_q, cnt_d;
    logic             port_q, port_d;
    logic             ack0_q, ack0_d, ack1_q, ack1_d, busy_q, busy_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic [WIDTH-1:0] alu_a_q, alu_a_d, alu_b_q, alu_b_d;
    logic [4:0]       alu_shamt_q, alu_shamt_d;
    logic [3:0]       alu_ops_q, alu_ops_d;
    logic             gnt_valid, gnt_port, capture;

    rr_arb2 u_rr_arb2 (
        .clk       (clk),
        .rst_n     (rst_n),
        .en        (state_q == IDLE),
        .req0      (Req0),
        .req1      (Req1),
        .gnt_valid (gnt_valid),
        .gnt_port  (gnt_port)
    );

    assign capture = (state_q == EXEC) && (cnt_q == 2'd0);

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        port_d      = port_q;
        result_d    = result_q;
        alu_a_d     = alu_a_q;
        alu_b_d     = alu_b_q;
        alu_shamt_d = alu_shamt_q;
        alu_ops_d   = alu_ops_q;
        case (state_q)
            IDLE: begin
                if (gnt_valid) begin
                    port_d      = gnt_port;
                    alu_a_d     = gnt_port ? A1 : A0;
                    alu_b_d     = gnt_port ? B1 : B0;
                    alu_shamt_d = gnt_port ? Shamt1 : Shamt0;
                    alu_ops_d   = gnt_port ? Op1 : Op0;
                    cnt_d       = CNT_INIT;
                    state_d     = EXEC;
                end
            end
            EXEC: begin
                if (capture) begin
                    result_d = AluOut;
                    state_d  = RESP;
                end else begin
                    cnt_d = cnt_q - 2'd1;
                end
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
        // Strobes are registered so they line up with the state they describe.
        busy_d = (state_d != IDLE);
        ack0_d = (state_d == RESP) && !port_d;
        ack1_d = (state_d == RESP) && port_d;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            cnt_q       <= 2'd0;
            port_q      <= 1'b0;
            ack0_q      <= 1'b0;
            ack1_q      <= 1'b0;
            busy_q      <= 1'b0;
            result_q    <= '0;
            alu_a_q     <= '0;
            alu_b_q     <= '0;
            alu_shamt_q <= '0;
            alu_ops_q   <= OP_PASS;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            port_q      <= port_d;
            ack0_q      <= ack0_d;
            ack1_q      <= ack1_d;
            busy_q      <= busy_d;
            result_q    <= result_d;
            alu_a_q     <= alu_a_d;
            alu_b_q     <= alu_b_d;
            alu_shamt_q <= alu_shamt_d;
            alu_ops_q   <= alu_ops_d;
        end
    end

`ifdef ALU_ARB_FLAGS_EN
    logic [3:0] flags_q, flags_d;

    always_comb begin
        flags_d = flags_q;
        if (capture) begin
            flags_d = {AluCarry, AluZero, AluSign, AluEqual};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            flags_q <= 4'b0;
        end else begin
            flags_q <= flags_d;
        end
    end

    assign {CarryOut, FlagZero, FlagSign, FlagEqual} = flags_q;
`else
    logic unused_flags;
    assign unused_flags = ^{AluCarry, AluZero, AluSign, AluEqual};
    assign {CarryOut, FlagZero, FlagSign, FlagEqual} = 4'b0;
`endif

    assign Ack0     = ack0_q;
    assign Ack1     = ack1_q;
    assign Busy     = busy_q;
    assign Result   = result_q;
    assign AluA     = alu_a_q;
    assign AluB     = alu_b_q;
    assign AluShamt = alu_shamt_q;
    assign AluOps   = alu_ops_q;

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Bench for alu_share_arbiter: one instance at ALU_LAT=1 and one at ALU_LAT=3, each with a behavioural ALU,
// checked every cycle against a transaction-level timing/arbitration model.
module tb_alu_share_arbiter;
    import alu_pkg::*;

    localparam int W    = 32;
    localparam int NDUT = 2;

    typedef struct {
        logic [3:0]   op;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [4:0]   sh;
    } txn_t;

    function automatic logic [35:0] alu_fn(input logic [3:0] op, input logic [W-1:0] a,
                                           input logic [W-1:0] b, input logic [4:0] sh);
        logic [32:0]  s;
        logic [W-1:0] r;
        logic         c;
        s = {1'b0, a} + {1'b0, b};
        c = 1'b0;
        case (op)
            OP_SLL:  r = a << sh;
            OP_SRL:  r = a >> sh;
            OP_SRA:  r = W'($signed(a) >>> sh);
            OP_AND:  r = a & b;
            OP_XOR:  r = a ^ b;
            OP_ADD:  begin r = s[31:0]; c = s[32]; end
            OP_DIFF: r = a - b;
            OP_PASS: r = a;
            OP_COMP: r = -b;
            default: r = '0;
        endcase
        return {c, (r == '0), r[W-1], (a == b), r};
    endfunction

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic         req0 [NDUT], req1 [NDUT];
    logic [3:0]   op0 [NDUT], op1 [NDUT];
    logic [W-1:0] a0 [NDUT], a1 [NDUT], b0 [NDUT], b1 [NDUT];
    logic [4:0]   sh0 [NDUT], sh1 [NDUT];
    logic         ack0 [NDUT], ack1 [NDUT], busy [NDUT];
    logic         carry [NDUT], fz [NDUT], fs [NDUT], fe [NDUT];
    logic [W-1:0] result [NDUT], alu_a [NDUT], alu_b [NDUT], alu_out [NDUT];
    logic [4:0]   alu_sh [NDUT];
    logic [3:0]   alu_ops [NDUT];
    logic         alu_c [NDUT], alu_z [NDUT], alu_s [NDUT], alu_e [NDUT];

    generate
        for (genvar gi = 0; gi < NDUT; gi++) begin : g_dut
            logic [35:0] env_r;
            alu_share_arbiter #(.WIDTH(W), .ALU_LAT(gi == 0 ? 1 : 3)) u_dut (
                .clk(clk), .rst_n(rst_n),
                .Req0(req0[gi]), .Req1(req1[gi]), .Op0(op0[gi]), .Op1(op1[gi]),
                .A0(a0[gi]), .A1(a1[gi]), .B0(b0[gi]), .B1(b1[gi]),
                .Shamt0(sh0[gi]), .Shamt1(sh1[gi]),
                .Ack0(ack0[gi]), .Ack1(ack1[gi]), .Result(result[gi]),
                .CarryOut(carry[gi]), .FlagZero(fz[gi]), .FlagSign(fs[gi]), .FlagEqual(fe[gi]),
                .Busy(busy[gi]), .AluA(alu_a[gi]), .AluB(alu_b[gi]),
                .AluShamt(alu_sh[gi]), .AluOps(alu_ops[gi]),
                .AluOut(alu_out[gi]), .AluCarry(alu_c[gi]), .AluZero(alu_z[gi]),
                .AluSign(alu_s[gi]), .AluEqual(alu_e[gi])
            );
            assign env_r       = alu_fn(alu_ops[gi], alu_a[gi], alu_b[gi], alu_sh[gi]);
            assign alu_out[gi] = env_r[31:0];
            assign alu_c[gi]   = env_r[35];
            assign alu_z[gi]   = env_r[34];
            assign alu_s[gi]   = env_r[33];
            assign alu_e[gi]   = env_r[32];
        end
    endgenerate

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Reference model: cycles since grant (-1 = idle), granted port, last winner, latched request.
    int           m_t, m_port, m_last;
    txn_t         m_txn;
    logic [W-1:0] m_res;
    logic [3:0]   m_flags;

    txn_t         q0[$], q1[$];
    int           order[$];
    int           cyc = 0;
    int           ack_cyc [2];
    int           n_ack [2];
    logic [W-1:0] ack_res [2];
    logic [3:0]   ack_flags [2];
    bit           eager, hold_mode;

    function automatic int lat_of(input int k);
        return (k == 0) ? 1 : 3;
    endfunction

    task automatic model_reset();
        m_t     = -1;
        m_port  = 0;
        m_last  = 1;
        m_txn   = '{OP_PASS, '0, '0, '0};
        m_res   = '0;
        m_flags = 4'b0;
    endtask

    task automatic drive_port(input int k, input int p, input bit on, input txn_t t);
        if (p == 0) begin
            req0[k] = on; op0[k] = t.op; a0[k] = t.a; b0[k] = t.b; sh0[k] = t.sh;
        end else begin
            req1[k] = on; op1[k] = t.op; a1[k] = t.a; b1[k] = t.b; sh1[k] = t.sh;
        end
    endtask

    function automatic int qsize(input int p);
        return (p == 0) ? q0.size() : q1.size();
    endfunction

    function automatic txn_t qfront(input int p);
        return (p == 0) ? q0[0] : q1[0];
    endfunction

    task automatic qpop(input int p);
        txn_t t;
        if (p == 0 && q0.size() > 0) t = q0.pop_front();
        if (p == 1 && q1.size() > 0) t = q1.pop_front();
    endtask

    task automatic kick(input int k);
        if (!req0[k] && q0.size() > 0) drive_port(k, 0, 1'b1, q0[0]);
        if (!req1[k] && q1.size() > 0) drive_port(k, 1, 1'b1, q1[0]);
    endtask

    task automatic clear_stats();
        order.delete();
        for (int p = 0; p < 2; p++) begin
            n_ack[p] = 0; ack_cyc[p] = 0; ack_res[p] = '0; ack_flags[p] = 4'b0;
        end
    endtask

    task automatic step(input int k);
        int         lat;
        bit         r0, r1, e_ack0, e_ack1, acked, cur;
        txn_t       t0, t1, idle_t;
        logic [3:0] e_flags;
        lat    = lat_of(k);
        r0     = req0[k];
        r1     = req1[k];
        t0     = '{op0[k], a0[k], b0[k], sh0[k]};
        t1     = '{op1[k], a1[k], b1[k], sh1[k]};
        idle_t = '{OP_PASS, '0, '0, '0};
        @(posedge clk);
        cyc++;
        if (m_t < 0) begin
            if (r0 || r1) begin
                m_port = (r0 && r1) ? 1 - m_last : (r1 ? 1 : 0);
                m_last = m_port;
                m_txn  = (m_port == 1) ? t1 : t0;
                m_t    = 0;
            end
        end else begin
            m_t++;
            if (m_t == lat) {m_flags, m_res} = alu_fn(m_txn.op, m_txn.a, m_txn.b, m_txn.sh);
            else if (m_t == lat + 1) m_t = -1;
        end
        #1;
        e_ack0 = (m_t == lat) && (m_port == 0);
        e_ack1 = (m_t == lat) && (m_port == 1);
`ifdef ALU_ARB_FLAGS_EN
        e_flags = m_flags;
`else
        e_flags = 4'b0;
`endif
        check("ack0", 64'(ack0[k]), 64'(e_ack0));
        check("ack1", 64'(ack1[k]), 64'(e_ack1));
        check("busy", 64'(busy[k]), 64'(m_t >= 0));
        check("result", 64'(result[k]), 64'(m_res));
        check("flags", 64'({carry[k], fz[k], fs[k], fe[k]}), 64'(e_flags));
        check("alu_ops", 64'(alu_ops[k]), 64'(m_txn.op));
        check("alu_a", 64'(alu_a[k]), 64'(m_txn.a));
        check("alu_b", 64'(alu_b[k]), 64'(m_txn.b));
        check("alu_sh", 64'(alu_sh[k]), 64'(m_txn.sh));
        for (int p = 0; p < 2; p++) begin
            acked = (p == 0) ? e_ack0 : e_ack1;
            cur   = (p == 0) ? req0[k] : req1[k];
            if (acked) begin
                n_ack[p]++;
                ack_cyc[p]   = cyc;
                ack_res[p]   = result[k];
                ack_flags[p] = {carry[k], fz[k], fs[k], fe[k]};
                order.push_back(p);
                $display("dut%0d port%0d ack cycle=%0d result=%08h", k, p, cyc, result[k]);
                qpop(p);
                if (qsize(p) > 0 && (hold_mode || (!eager && $urandom_range(1) == 1)))
                    drive_port(k, p, 1'b1, qfront(p));
                else
                    drive_port(k, p, 1'b0, idle_t);
            end else if (!cur && qsize(p) > 0 && (eager || $urandom_range(3) == 0)) begin
                drive_port(k, p, 1'b1, qfront(p));
            end
        end
    endtask

    task automatic run_until_idle(input int k, input int budget);
        int n;
        n = 0;
        while ((q0.size() > 0 || q1.size() > 0 || m_t >= 0 || req0[k] || req1[k]) && n < budget) begin
            step(k);
            n++;
        end
        check("run_within_budget", 64'(n < budget), 64'(1));
    endtask

    task automatic clear_inputs();
        txn_t z;
        z = '{OP_PASS, '0, '0, '0};
        for (int k = 0; k < NDUT; k++) begin
            drive_port(k, 0, 1'b0, z);
            drive_port(k, 1, 1'b0, z);
        end
        q0.delete();
        q1.delete();
    endtask

    task automatic do_reset(input int k);
        rst_n = 1'b0;
        clear_inputs();
        model_reset();
        clear_stats();
        repeat (2) @(posedge clk);
        #1;
        check("rst_ack", 64'({ack0[k], ack1[k]}), 64'(0));
        check("rst_busy", 64'(busy[k]), 64'(0));
        check("rst_result", 64'(result[k]), 64'(0));
        check("rst_alu_ops", 64'(alu_ops[k]), 64'(OP_PASS));
        check("rst_alu_ab", 64'({alu_a[k], alu_b[k]}), 64'(0));
        check("rst_flags", 64'({carry[k], fz[k], fs[k], fe[k]}), 64'(0));
        rst_n = 1'b1;
    endtask

    function automatic txn_t rand_txn();
        txn_t t;
        case ($urandom_range(8))
            0: t.op = OP_SLL;  1: t.op = OP_SRL;  2: t.op = OP_SRA;
            3: t.op = OP_AND;  4: t.op = OP_XOR;  5: t.op = OP_ADD;
            6: t.op = OP_DIFF; 7: t.op = OP_PASS; default: t.op = OP_COMP;
        endcase
        t.a  = ($urandom_range(7) == 0) ? '1 : W'($urandom);
        t.b  = ($urandom_range(3) == 0) ? t.a : W'($urandom);
        t.sh = 5'($urandom_range(31));
        return t;
    endfunction

    task automatic random_phase(input int k, input int n_per_port);
        eager = 1'b0;
        for (int i = 0; i < n_per_port; i++) begin
            q0.push_back(rand_txn());
            q1.push_back(rand_txn());
        end
        run_until_idle(k, n_per_port * 40);
        check("rand_count0", 64'(n_ack[0]), 64'(n_per_port));
        check("rand_count1", 64'(n_ack[1]), 64'(n_per_port));
    endtask

    initial begin
        int   start;
        txn_t t;
        rst_n     = 1'b1;
        eager     = 1'b1;
        hold_mode = 1'b0;
        clear_inputs();
        model_reset();
        clear_stats();

        // ---------------- ALU_LAT = 1 instance ----------------
        do_reset(0);
        q0.push_back('{OP_ADD, 32'd5, 32'd7, 5'd0});
        start = cyc;
        kick(0);
        run_until_idle(0, 20);
        check("single_result", 64'(ack_res[0]), 64'(12));
        check("single_latency", 64'(ack_cyc[0] - start), 64'(2));
        check("single_no_ack1", 64'(n_ack[1]), 64'(0));

        do_reset(0);
        q0.push_back('{OP_XOR, 32'hFF, 32'h0F, 5'd0});
        q1.push_back('{OP_ADD, 32'd1, 32'd2, 5'd0});
        kick(0);
        run_until_idle(0, 20);
        check("tie_first_port", 64'(order[0]), 64'(0));
        check("tie_second_port", 64'(order[1]), 64'(1));
        check("tie_result0", 64'(ack_res[0]), 64'(32'hF0));
        check("tie_result1", 64'(ack_res[1]), 64'(3));
        check("tie_gap", 64'(ack_cyc[1] - ack_cyc[0]), 64'(3));

        clear_stats();
        hold_mode = 1'b1;
        for (int i = 0; i < 2; i++) begin
            q0.push_back(rand_txn());
            q1.push_back(rand_txn());
        end
        kick(0);
        run_until_idle(0, 40);
        hold_mode = 1'b0;
        check("alt_len", 64'(order.size()), 64'(4));
        for (int i = 0; i < 4; i++) check("alt_order", 64'(order[i]), 64'(i % 2));

        // Abort mid-EXEC: Result was nonzero from the alternation run.
        clear_stats();
        q1.push_back('{OP_ADD, 32'd9, 32'd9, 5'd0});
        kick(0);
        step(0);
        check("abort_busy_before", 64'(busy[0]), 64'(1));
        #3;
        rst_n = 1'b0;
        #1;
        check("abort_busy", 64'(busy[0]), 64'(0));
        check("abort_result", 64'(result[0]), 64'(0));
        check("abort_ack", 64'({ack0[0], ack1[0]}), 64'(0));
        clear_inputs();
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) step(0);
        check("abort_no_ack", 64'(n_ack[0] + n_ack[1]), 64'(0));
        q0.push_back('{OP_AND, 32'hF0F0, 32'hFF00, 5'd0});
        q1.push_back('{OP_DIFF, 32'd10, 32'd4, 5'd0});
        kick(0);
        run_until_idle(0, 20);
        check("post_abort_first", 64'(order[0]), 64'(0));
        check("post_abort_res0", 64'(ack_res[0]), 64'(32'hF000));

        clear_stats();
        random_phase(0, 120);

        // ---------------- ALU_LAT = 3 instance ----------------
        eager = 1'b1;
        do_reset(1);
        t = '{OP_COMP, W'($urandom), 32'd3, 5'd0};
        q1.push_back(t);
        start = cyc;
        kick(1);
        run_until_idle(1, 20);
        check("comp_result", 64'(ack_res[1]), 64'(32'hFFFFFFFD));
        check("comp_latency", 64'(ack_cyc[1] - start), 64'(4));
        check("comp_no_ack0", 64'(n_ack[0]), 64'(0));

        clear_stats();
        q0.push_back('{OP_ADD, 32'hFFFFFFFF, 32'd1, 5'd0});
        kick(1);
        run_until_idle(1, 20);
        check("flag_result", 64'(ack_res[0]), 64'(0));
`ifdef ALU_ARB_FLAGS_EN
        check("flag_zero", 64'(ack_flags[0][2]), 64'(1));
        check("flag_carry", 64'(ack_flags[0][3]), 64'(1));
`else
        check("flag_zero", 64'(ack_flags[0][2]), 64'(0));
        check("flag_carry", 64'(ack_flags[0][3]), 64'(0));
`endif

        clear_stats();
        random_phase(1, 120);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/alu_share_arbiter.md
Name: alu_share_arbiter

Overview:
- Shares the single ALU datapath between two requesters: port 0 is the execute stage, port 1 is the address/branch unit.
- Registers the operands and opcode of the granted request and drives the ALU from those registers.
- Waits a fixed number of cycles, captures the ALU result, and returns it with a one-cycle Ack.
- Uses round-robin arbitration when both ports request in the same cycle.

Parameters:
- WIDTH, 32, datapath width of operands and result.
- ALU_LAT, 1, cycles the ALU inputs are held stable before the result is captured; legal range 1..4.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- Req0 / Req1  input  1  request from port 0 / port 1; held high until Ack.
- Op0 / Op1  input  4  ALUOps code, held stable with Req.
- A0 / A1, B0 / B1  input  WIDTH  operands, held stable with Req.
- Shamt0 / Shamt1  input  5  immediate shift amount.
- Ack0 / Ack1  output  1  one-cycle completion strobe to port 0 / port 1.
- Result  output  WIDTH  captured ALU output; valid while Ack is high, held until the next capture.
- CarryOut, FlagZero, FlagSign, FlagEqual  output  1 each  captured ALU status.
- Busy  output  1  high in EXEC and RESP.
- AluA, AluB  output  WIDTH  registered operands to the ALU.
- AluShamt  output  5  registered shift amount to the ALU.
- AluOps  output  4  registered opcode to the ALU.
- AluOut  input  WIDTH  ALU result.
- AluCarry, AluZero, AluSign, AluEqual  input  1 each  ALU status.

Behaviour:
- Reset (asynchronous, rst_n low):
  - state = IDLE; LastGnt = 1, so port 0 wins the first tie.
  - Ack0, Ack1, Busy = 0.
  - Result, AluA, AluB, AluShamt = 0; AluOps = 4'b1110 (pass).
  - All captured flags = 0.
- State machine: IDLE, EXEC, RESP.
- IDLE, no Req: stay in IDLE; ALU operand registers hold their values.
- IDLE, exactly one Req: grant that port.
- IDLE, both Req: grant the port that is not LastGnt, then update LastGnt.
- On grant: latch that port's Op/A/B/Shamt into the Alu* registers, load Cnt = ALU_LAT-1, go to EXEC.
- EXEC: Alu* registers are stable.
  - Cnt != 0: decrement Cnt.
  - Cnt == 0: capture AluOut into Result and the flags into their output registers, go to RESP.
- RESP: assert the granted port's Ack for exactly this one cycle, then return to IDLE.
  - Req lines are ignored in RESP.
  - The requester must drop Req on the edge that ends its Ack cycle.
  - If Req is still high in the following IDLE cycle, it is a new request.
- Latency, Req sampled to Ack high: ALU_LAT+1 cycles. Throughput: one operation per ALU_LAT+2 cycles.
- Ack0 and Ack1 are never high together; Ack is never asserted without a prior grant.
- A Req arriving during EXEC/RESP waits; the loser of a tie is served next.
- A port requesting continuously while the other is idle is served every ALU_LAT+2 cycles.
- The arbiter does no arithmetic and does not decode opcodes; Op is passed through unchanged.
- Reset asserted mid-EXEC or mid-RESP: abort immediately to IDLE; no Ack is issued; Result clears to 0.

Optional Feature:
- Macro: ALU_ARB_FLAGS_EN.
- Defined: CarryOut, FlagZero, FlagSign, FlagEqual are captured from the ALU alongside Result and held until the next capture.
- Undefined: the four flag outputs are tied to 0 and no flag registers are synthesised.
- Result and Ack behaviour are identical in both builds.

Decomposition:
- Shared package alu_pkg:
  - ALUOps constants: OP_AND=4'b1000, OP_XOR=4'b1001, OP_ADD=4'b1010, OP_DIFF=4'b1011, OP_PASS=4'b1110, OP_COMP=4'b1111, and the shift codes 4'b0000/0001/0010.
  - FSM state encoding: IDLE=2'd0, EXEC=2'd1, RESP=2'd2.
- Sub-module rr_arb2: two-request round-robin grant with the LastGnt register.
- FSM, counter and operand/result registers stay in the top module.

Test Plan:
- Single request: Req0 with Op=1010, A0=5, B0=7, ALU_LAT=1 -> Ack0 two cycles after Req0 sampled; Result=12; Ack1 stays 0.
- Tie after reset: Req0 (XOR, A=0xFF, B=0x0F) and Req1 (ADD, A=1, B=2) together -> port 0 first, Result=0xF0; then port 1, Result=3, three cycles after Ack0.
- Alternation: both ports request continuously for 4 operations -> grant order 0,1,0,1; no double Acks.
- Complement with ALU_LAT=3: Req1 with Op=1111, B1=3 -> AluOps held for 3 cycles; Ack1 four cycles after request; Result=0xFFFFFFFD.
- Reset mid-EXEC: rst_n low one cycle after grant -> no Ack; Result=0; Busy=0; a fresh request afterwards goes to port 0.
- Flags (ALU_ARB_FLAGS_EN defined): ADD A=0xFFFFFFFF, B=1 -> Result=0, FlagZero=1, CarryOut=1. Same case with the macro undefined -> all flags 0.
